// File: rtl/instr_mem_pipe_if.sv
`default_nettype none
// ============================================================================
// Module      : instr_mem_pipe_if
// Description : Fetch request/response, flush, program-load and busy bundle
//               that connects PC/fetch logic to instr_mem_pipe.
//               master : fetch unit / loader side
//               slave  : instruction memory side
//               Request  : req_valid, req_ready, req_pc
//               Response : rsp_valid, rsp_ready, rsp_instr, rsp_pc, rsp_fault
//               Control  : flush, load_en, load_addr, load_data, busy
// Revision    : 1.0 - initial release
// ============================================================================
interface instr_mem_pipe_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int IDX_W  = 8
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_pc;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_instr;
    logic [ADDR_W-1:0] rsp_pc;
    logic              rsp_fault;
    logic              flush;
    logic              load_en;
    logic [IDX_W-1:0]  load_addr;
    logic [DATA_W-1:0] load_data;
    logic              busy;

    modport master (
        output req_valid, req_pc, rsp_ready, flush, load_en, load_addr, load_data,
        input  req_ready, rsp_valid, rsp_instr, rsp_pc, rsp_fault, busy
    );

    modport slave (
        input  req_valid, req_pc, rsp_ready, flush, load_en, load_addr, load_data,
        output req_ready, rsp_valid, rsp_instr, rsp_pc, rsp_fault, busy
    );
endinterface
`default_nettype wire

// File: rtl/instr_mem_pipe.sv
`default_nettype none
// ============================================================================
// Module      : instr_mem_pipe
// Description : Pipelined instruction memory with a program-load port.
//               A fetch accepted on a rising edge reads the array into stage
//               0; the word then walks through LATENCY stages and is
//               presented from the last stage with its PC and a fault flag.
//               Misaligned or out-of-range PCs return NOP_WORD with fault=1.
// Ports       : clk, reset (sync, active-high)
//               bus (slave modport) : fetch req/rsp handshakes, flush,
//                                     program load, busy
// Revision    : 1.0 - initial release
// ============================================================================
module instr_mem_pipe #(
    parameter int                DATA_W    = 32,
    parameter int                ADDR_W    = 32,
    parameter int                DEPTH     = 256,   // power of two, >= 2
    parameter int                LATENCY   = 1,     // 1..4
    parameter int                BYTE_ADDR = 1,
    parameter logic [DATA_W-1:0] NOP_WORD  = '0
) (
    input  logic               clk,
    input  logic               reset,
    instr_mem_pipe_if.slave    bus
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int LAST  = LATENCY - 1;

    // Program storage: not reset, contents survive a pipeline reset.
    logic [DATA_W-1:0] mem_q [DEPTH];

    // Pipeline stage registers
    logic              valid_q [LATENCY];
    logic [ADDR_W-1:0] pc_q    [LATENCY];
    logic [DATA_W-1:0] instr_q [LATENCY];
    logic              fault_q [LATENCY];

    logic [IDX_W-1:0]  w_idx;
    logic              w_fault;
    logic              w_advance;
    logic              w_accept;
    logic [DATA_W-1:0] w_instr_d;
    logic              w_busy;

    // ------------------------------------------------------------------
    // Address decode: word index and fault. Any PC bit above the index
    // field being set is out of range; addresses never alias.
    // ------------------------------------------------------------------
    if (BYTE_ADDR != 0) begin : g_byte_addr
        assign w_idx   = bus.req_pc[IDX_W+1:2];
        assign w_fault = (bus.req_pc[1:0] != 2'b00) ||
                         ((bus.req_pc >> (IDX_W + 2)) != '0);
    end else begin : g_word_addr
        assign w_idx   = bus.req_pc[IDX_W-1:0];
        assign w_fault = (bus.req_pc >> IDX_W) != '0;
    end

    // The whole pipe stalls only when the output holds an untaken response.
    assign w_advance = !(valid_q[LAST] && !bus.rsp_ready);
    // Load and flush steal the acceptance slot, so a load never races a read.
    assign bus.req_ready = w_advance && !bus.load_en && !bus.flush && !reset;
    assign w_accept      = bus.req_valid && bus.req_ready;

    // Faulted fetches never index the array.
    assign w_instr_d = w_fault ? NOP_WORD : mem_q[w_idx];

    always_ff @(posedge clk) begin
        if (!reset && bus.load_en) begin
            mem_q[bus.load_addr] <= bus.load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < LATENCY; i++) begin
                valid_q[i] <= 1'b0;
                pc_q[i]    <= '0;
                instr_q[i] <= '0;
                fault_q[i] <= 1'b0;
            end
        end else begin
            if (w_advance) begin
                valid_q[0] <= w_accept;
                if (w_accept) begin
                    pc_q[0]    <= bus.req_pc;
                    instr_q[0] <= w_instr_d;
                    fault_q[0] <= w_fault;
                end
                for (int i = 1; i < LATENCY; i++) begin
                    valid_q[i] <= valid_q[i-1];
                    pc_q[i]    <= pc_q[i-1];
                    instr_q[i] <= instr_q[i-1];
                    fault_q[i] <= fault_q[i-1];
                end
            end
            // Flush drops every in-flight fetch, including a response that
            // the consumer is taking in this same cycle.
            if (bus.flush) begin
                for (int i = 0; i < LATENCY; i++) begin
                    valid_q[i] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        w_busy = 1'b0;
        for (int i = 0; i < LATENCY; i++) begin
            w_busy = w_busy | valid_q[i];
        end
    end

    assign bus.busy      = w_busy;
    assign bus.rsp_valid = valid_q[LAST];
    assign bus.rsp_pc    = pc_q[LAST];
    assign bus.rsp_instr = instr_q[LAST];
    assign bus.rsp_fault = fault_q[LAST];
endmodule
`default_nettype wire

// File: tb/tb_instr_mem_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_mem_pipe
// Description : Self-checking bench for instr_mem_pipe (LATENCY=3, byte PCs,
//               DEPTH=256). Accepted fetches push an expected response into
//               a scoreboard queue; delivered responses pop and compare.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_mem_pipe;
    localparam int          LAT = 3;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fault;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;
    exp_t sb [$];
    logic [31:0] model_mem [256];

    always #5 clk = ~clk;

    instr_mem_pipe_if #(.DATA_W(32), .ADDR_W(32), .IDX_W(8)) bus ();

    instr_mem_pipe #(
        .DATA_W(32), .ADDR_W(32), .DEPTH(256), .LATENCY(LAT),
        .BYTE_ADDR(1), .NOP_WORD(NOP)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] pc);
        exp_t e;
        e.pc    = pc;
        e.fault = (pc[1:0] != 2'b00) || (pc[31:10] != '0);
        e.instr = e.fault ? NOP : model_mem[pc[9:2]];
        return e;
    endfunction

    // One clock: score the cycle at the falling edge, then return 1 time
    // unit after the rising edge so new inputs are applied away from it.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (reset) begin
            sb.delete();
        end else begin
            if (bus.rsp_valid && bus.rsp_ready && !bus.flush) begin
                if (sb.size() == 0) begin
                    check("unexpected_rsp", 64'(bus.rsp_pc), 64'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    check("rsp_pc",    64'(bus.rsp_pc),    64'(e.pc));
                    check("rsp_instr", 64'(bus.rsp_instr), 64'(e.instr));
                    check("rsp_fault", 64'(bus.rsp_fault), 64'(e.fault));
                end
            end
            if (bus.req_valid && bus.req_ready) sb.push_back(model(bus.req_pc));
            if (bus.flush) sb.delete();
            if (bus.load_en) model_mem[bus.load_addr] = bus.load_data;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        bus.req_valid = 1'b0;
        for (int k = 0; k < 40 && (sb.size() != 0 || bus.busy); k++) tick();
        check({tag, "_drain_left"}, 64'(sb.size()), 64'd0);
        check({tag, "_drain_busy"}, 64'(bus.busy), 64'd0);
    endtask

    task automatic fetch1(input logic [31:0] pc);
        bus.req_valid = 1'b1;
        bus.req_pc    = pc;
        tick();
        bus.req_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] next_pc;
        logic [31:0] h_instr, h_pc;
        logic        h_fault;

        bus.req_valid = 1'b0;
        bus.req_pc    = '0;
        bus.rsp_ready = 1'b1;
        bus.flush     = 1'b0;
        bus.load_en   = 1'b0;
        bus.load_addr = '0;
        bus.load_data = '0;

        // ---- reset state
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("rst_rsp_instr", 64'(bus.rsp_instr), 64'd0);
        check("rst_rsp_pc",    64'(bus.rsp_pc),    64'd0);
        check("rst_rsp_fault", 64'(bus.rsp_fault), 64'd0);
        check("rst_busy",      64'(bus.busy),      64'd0);

        // ---- program load mem[0..7]; a pending request must be held off
        for (int i = 0; i < 8; i++) begin
            bus.load_en   = 1'b1;
            bus.load_addr = 8'(i);
            bus.load_data = (i == 1) ? 32'h1088_0007 : 32'hA000_0000 + 32'(i) * 32'h0101;
            bus.req_valid = (i == 0);
            bus.req_pc    = 32'h0;
            #1;
            if (i == 0) check("load_blocks_req", 64'(bus.req_ready), 64'd0);
            tick();
        end
        bus.load_en   = 1'b0;
        bus.req_valid = 1'b0;

        // ---- single fetch pc=4, latency
        bus.req_valid = 1'b1;
        bus.req_pc    = 32'd4;
        #1;
        check("fetch_ready", 64'(bus.req_ready), 64'd1);
        tick();
        bus.req_valid = 1'b0;
        for (int k = 1; k <= LAT; k++) begin
            #1;
            check("fetch_lat_valid", 64'(bus.rsp_valid), 64'(k == LAT));
            tick();
        end
        drain("fetch");

        // ---- streaming pc=0,4,8,12 back to back
        for (int j = 0; j < LAT + 5; j++) begin
            bus.req_valid = (j < 4);
            bus.req_pc    = 32'(j * 4);
            #1;
            check("stream_valid", 64'(bus.rsp_valid), 64'((j >= LAT) && (j < LAT + 4)));
            tick();
        end
        drain("stream");

        // ---- back-pressure: consumer stalls for 5 cycles
        next_pc = 32'd0;
        h_instr = '0;
        h_pc    = '0;
        h_fault = 1'b0;
        bus.rsp_ready = 1'b0;
        for (int j = 0; j < 5; j++) begin
            bus.req_valid = 1'b1;
            bus.req_pc    = next_pc;
            #1;
            check("bp_req_ready", 64'(bus.req_ready), 64'(j < LAT));
            check("bp_rsp_valid", 64'(bus.rsp_valid), 64'(j >= LAT));
            if (j == LAT) begin
                h_instr = bus.rsp_instr;
                h_pc    = bus.rsp_pc;
                h_fault = bus.rsp_fault;
                check("bp_first_pc", 64'(h_pc), 64'd0);
            end else if (j > LAT) begin
                check("bp_hold_instr", 64'(bus.rsp_instr), 64'(h_instr));
                check("bp_hold_pc",    64'(bus.rsp_pc),    64'(h_pc));
                check("bp_hold_fault", 64'(bus.rsp_fault), 64'(h_fault));
            end
            if (bus.req_ready) next_pc = next_pc + 32'd4;
            tick();
        end
        bus.rsp_ready = 1'b1;
        drain("bp");

        // ---- faults: misaligned, out of range, then a good fetch
        bus.req_valid = 1'b1;
        bus.req_pc = 32'd6;    tick();
        bus.req_pc = 32'd1024; tick();
        bus.req_pc = 32'd8;    tick();
        drain("fault");

        // ---- flush with two fetches in flight
        bus.req_valid = 1'b1;
        bus.req_pc = 32'd16; tick();
        bus.req_pc = 32'd20; tick();
        bus.flush  = 1'b1;
        bus.req_pc = 32'd24;
        #1;
        check("flush_req_ready", 64'(bus.req_ready), 64'd0);
        tick();
        bus.flush     = 1'b0;
        bus.req_valid = 1'b0;
        #1;
        check("flush_busy",      64'(bus.busy),      64'd0);
        check("flush_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        fetch1(32'd28);
        drain("post_flush");

        // ---- synchronous reset mid-stream
        bus.req_valid = 1'b1;
        bus.req_pc = 32'd0; tick();
        bus.req_pc = 32'd4; tick();
        bus.req_pc = 32'd8; tick();
        reset = 1'b1;
        bus.req_pc = 32'd12;
        tick();
        reset = 1'b0;
        bus.req_valid = 1'b0;
        #1;
        check("mid_rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("mid_rst_rsp_instr", 64'(bus.rsp_instr), 64'd0);
        check("mid_rst_rsp_pc",    64'(bus.rsp_pc),    64'd0);
        check("mid_rst_rsp_fault", 64'(bus.rsp_fault), 64'd0);
        check("mid_rst_busy",      64'(bus.busy),      64'd0);
        fetch1(32'd4);
        drain("post_reset");

        // ---- load mem[3] while a pc=12 fetch is in flight
        fetch1(32'd12);
        bus.load_en   = 1'b1;
        bus.load_addr = 8'd3;
        bus.load_data = 32'hDEAD_BEEF;
        bus.req_valid = 1'b1;
        bus.req_pc    = 32'd12;
        #1;
        check("load_cycle_req_ready", 64'(bus.req_ready), 64'd0);
        tick();
        bus.load_en = 1'b0;
        fetch1(32'd12);
        drain("load_order");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire
